// File: rtl/led_pkg.sv
// Shared encodings and pattern helpers for the LED mode scheduler.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_ROTL   = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [7:0] SEED_ROTL   = 8'h01;
  localparam logic [7:0] SEED_BOUNCE = 8'h01;
  localparam logic [7:0] SEED_FILL   = 8'h00;
  localparam logic [7:0] SEED_BLINK  = 8'h00;

  function automatic logic [7:0] mode_seed(input mode_e m);
    case (m)
      MODE_ROTL:   mode_seed = SEED_ROTL;
      MODE_BOUNCE: mode_seed = SEED_BOUNCE;
      MODE_FILL:   mode_seed = SEED_FILL;
      default:     mode_seed = SEED_BLINK;
    endcase
  endfunction

  // dir_right only matters for BOUNCE.
  function automatic logic [7:0] next_pattern(input mode_e m, input logic [7:0] cur,
                                              input logic dir_right);
    case (m)
      MODE_ROTL:   next_pattern = {cur[6:0], cur[7]};
      MODE_BOUNCE: next_pattern = dir_right ? {1'b0, cur[7:1]} : {cur[6:0], 1'b0};
      MODE_FILL:   next_pattern = (cur == 8'hFF) ? 8'h00 : {cur[6:0], 1'b1};
      default:     next_pattern = ~cur;
    endcase
  endfunction

endpackage

// File: rtl/led_step_timer.sv
// Step-rate counter: counts while en, pulses tick combinationally at STEP_DIV-1.
module led_step_timer #(
  parameter int unsigned STEP_DIV = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [31:0] TC = 32'(STEP_DIV - 1);

  logic [31:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) cnt_d = '0;
    else if (en)     cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_mode_scheduler.sv
// LED pattern scheduler: four modes, run/pause FSM, button-driven mode select.
// Define LED_DEBOUNCE_EN to add a DEB_CYCLES stability filter on the mode button.
module led_mode_scheduler
  import led_pkg::*;
#(
  parameter int unsigned STEP_DIV   = 500000,
  parameter int unsigned DEB_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       mode_btn,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       step
);

  if (STEP_DIV < 2) begin : g_bad_step_div
    $error("STEP_DIV must be at least 2");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
    $error("DEB_CYCLES must be at least 1");
  end

  logic       run_s1_q, run_s_q;
  logic       btn_s1_q, btn_s_q;
  logic       btn_acc, btn_prev_q;
  logic       mode_edge, tick;
  state_e     state_q;
  mode_e      mode_q, mode_inc;
  logic [7:0] led_q, led_step;
  logic       dir_q;
  logic       step_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_s1_q <= 1'b0;
      run_s_q  <= 1'b0;
      btn_s1_q <= 1'b0;
      btn_s_q  <= 1'b0;
    end else begin
      run_s1_q <= run;
      run_s_q  <= run_s1_q;
      btn_s1_q <= mode_btn;
      btn_s_q  <= btn_s1_q;
    end
  end

`ifdef LED_DEBOUNCE_EN
  localparam logic [31:0] DEB_TC = 32'(DEB_CYCLES - 1);

  logic        btn_deb_q;
  logic [31:0] deb_cnt_q;

  // Level is accepted only after DEB_CYCLES consecutive cycles away from the current one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_deb_q <= 1'b0;
      deb_cnt_q <= '0;
    end else if (btn_s_q != btn_deb_q) begin
      if (deb_cnt_q == DEB_TC) begin
        btn_deb_q <= btn_s_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 32'd1;
      end
    end else begin
      deb_cnt_q <= '0;
    end
  end

  assign btn_acc = btn_deb_q;
`else
  assign btn_acc = btn_s_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) btn_prev_q <= 1'b0;
    else       btn_prev_q <= btn_acc;
  end

  assign mode_edge = btn_acc & ~btn_prev_q;
  assign mode_inc  = mode_e'(mode_q + 2'd1);
  assign led_step  = next_pattern(mode_q, led_q, dir_q);

  led_step_timer #(
    .STEP_DIV(STEP_DIV)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .en   (state_q == ST_RUN),
    .clr  (mode_edge),
    .tick (tick)
  );

  // A mode change wins over a coincident step: the seed loads and no step pulse is emitted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ROTL;
      led_q   <= SEED_ROTL;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:  if (run_s_q)  state_q <= ST_RUN;
        ST_RUN:   if (!run_s_q) state_q <= ST_PAUSE;
        ST_PAUSE: if (run_s_q)  state_q <= ST_RUN;
        default:  state_q <= ST_IDLE;
      endcase

      step_q <= tick & ~mode_edge;

      if (mode_edge) begin
        mode_q <= mode_inc;
        led_q  <= mode_seed(mode_inc);
        dir_q  <= 1'b0;
      end else if (tick) begin
        led_q <= led_step;
        if (mode_q == MODE_BOUNCE) begin
          if (led_step == 8'h80)      dir_q <= 1'b1;
          else if (led_step == 8'h01) dir_q <= 1'b0;
        end
      end
    end
  end

  assign led  = led_q;
  assign mode = mode_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Directed bench for led_mode_scheduler with STEP_DIV=4, DEB_CYCLES=3.
module tb_led_mode_scheduler;

  logic       clk;
  logic       reset;
  logic       run;
  logic       mode_btn;
  logic [7:0] led;
  logic [1:0] mode;
  logic       step;

  int checks = 0;
  int errors = 0;

  led_mode_scheduler #(
    .STEP_DIV  (4),
    .DEB_CYCLES(3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .mode_btn(mode_btn),
    .led     (led),
    .mode    (mode),
    .step    (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns the number of falling edges until step is seen high.
  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (step !== 1'b1 && n < 60);
    chk("step_seen", {31'd0, step}, 32'd1);
  endtask

  task automatic press();
    mode_btn = 1'b1;
    repeat (10) @(negedge clk);
    mode_btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  logic [7:0] bounce_exp [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                  8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
  logic [7:0] fill_exp [10]   = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                  8'h00, 8'h01};

  initial begin
    int n;
    int pulses;
    int k;
    int exp_lat;

`ifdef LED_DEBOUNCE_EN
    k       = 2;
    exp_lat = 6;
`else
    k       = 5;
    exp_lat = 3;
`endif

    reset    = 1'b1;
    run      = 1'b0;
    mode_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_led", {24'd0, led}, 32'h01);
    chk("rst_mode", {30'd0, mode}, 32'd0);
    chk("rst_step", {31'd0, step}, 32'd0);

    reset = 1'b0;
    run   = 1'b1;
    wait_step(n);
    chk("first_step_lat", n, 7);
    chk("rotl_1", {24'd0, led}, 32'h02);
    @(negedge clk);
    chk("step_one_cycle", {31'd0, step}, 32'd0);
    wait_step(n);
    chk("step_interval", n, 3);
    chk("rotl_2", {24'd0, led}, 32'h04);

    // Pause mid-count: counter holds at 3, so resuming steps immediately once RUN.
    run    = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (step) pulses++;
    end
    chk("pause_pulses", pulses, 0);
    chk("pause_led", {24'd0, led}, 32'h04);
    run = 1'b1;
    wait_step(n);
    chk("resume_lat", n, 4);
    chk("rotl_3", {24'd0, led}, 32'h08);

    // run_s falls in the terminal-count cycle: step still happens, then PAUSE.
    @(negedge clk);
    run = 1'b0;
    wait_step(n);
    chk("tc_fall_lat", n, 3);
    chk("tc_fall_led", {24'd0, led}, 32'h10);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (step) pulses++;
    end
    chk("tc_fall_paused", pulses, 0);

    mode_btn = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mode == 2'd0 && n < 20);
    chk("mode_lat", n, exp_lat);
    chk("bounce_mode", {30'd0, mode}, 32'd1);
    chk("bounce_seed", {24'd0, led}, 32'h01);
    mode_btn = 1'b0;
    repeat (10) @(negedge clk);

    run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_step(n);
      chk($sformatf("bounce_%0d", i), {24'd0, led}, {24'd0, bounce_exp[i]});
    end
    run = 1'b0;
    repeat (10) @(negedge clk);

    press();
    chk("fill_mode", {30'd0, mode}, 32'd2);
    chk("fill_seed", {24'd0, led}, 32'h00);
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_step(n);
      chk($sformatf("fill_%0d", i), {24'd0, led}, {24'd0, fill_exp[i]});
    end
    run = 1'b0;
    repeat (10) @(negedge clk);

    press();
    chk("blink_mode", {30'd0, mode}, 32'd3);
    chk("blink_seed", {24'd0, led}, 32'h00);
    run = 1'b1;
    wait_step(n);
    chk("blink_1", {24'd0, led}, 32'hFF);
    wait_step(n);
    chk("blink_2", {24'd0, led}, 32'h00);

    // Mode edge timed onto the terminal-count edge eight cycles after this step.
    repeat (k) @(negedge clk);
    mode_btn = 1'b1;
    repeat (8 - k) @(negedge clk);
    chk("coin_mode", {30'd0, mode}, 32'd0);
    chk("coin_led", {24'd0, led}, 32'h01);
    chk("coin_step", {31'd0, step}, 32'd0);
    repeat (4) @(negedge clk);
    chk("coin_next_step", {31'd0, step}, 32'd1);
    chk("coin_next_led", {24'd0, led}, 32'h02);
    mode_btn = 1'b0;

    run = 1'b0;
    repeat (10) @(negedge clk);
    mode_btn = 1'b1;
    repeat (2) @(negedge clk);
    mode_btn = 1'b0;
    repeat (12) @(negedge clk);
`ifdef LED_DEBOUNCE_EN
    chk("glitch_mode", {30'd0, mode}, 32'd0);
    press();
`else
    chk("glitch_mode", {30'd0, mode}, 32'd1);
`endif
    chk("pre_bounce_mode", {30'd0, mode}, 32'd1);
    chk("pre_bounce_led", {24'd0, led}, 32'h01);

    run = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_step(n);
      chk($sformatf("bounce_r_%0d", i), {24'd0, led}, {24'd0, bounce_exp[i]});
    end

    // Asynchronous reset while moving right at 8'h20 with step still high.
    #2 reset = 1'b1;
    #1;
    chk("async_rst_led", {24'd0, led}, 32'h01);
    chk("async_rst_mode", {30'd0, mode}, 32'd0);
    chk("async_rst_step", {31'd0, step}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_step(n);
    chk("restart_lat", n, 7);
    chk("restart_led", {24'd0, led}, 32'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_mode_scheduler.md
LED_MODE_SCHEDULER -- requirements
Module: led_mode_scheduler

Interface
REQ-001 Parameter STEP_DIV, default 500000, clk cycles per pattern step (legal range 2..2^32-1).
REQ-002 Parameter DEB_CYCLES, default 20000, stable cycles required by the debounce filter.
REQ-003 clk  in  1  system clock; every flop SHALL be clocked on its rising edge.
REQ-004 reset  in  1  reset, asynchronous and active-high.
REQ-005 run  in  1  level input: 1 = advance the pattern, 0 = pause. Asynchronous to clk.
REQ-006 mode_btn  in  1  raw push-button; each accepted rising edge advances the mode. Asynchronous to clk.
REQ-007 led  out  8  LED drive; bit0 is the rightmost LED.
REQ-008 mode  out  2  current mode: 0 ROTL, 1 BOUNCE, 2 FILL, 3 BLINK.
REQ-009 step  out  1  one-cycle pulse in the same cycle that led updates because of a step.

Function
REQ-010 run and mode_btn SHALL each pass through a 2-flop synchronizer; all logic SHALL use only the synchronized copies.
REQ-011 FSM states: IDLE, RUN, PAUSE. Transitions: IDLE->RUN and PAUSE->RUN when run_s=1; RUN->PAUSE when run_s=0.
REQ-012 In IDLE the block SHALL hold led at the seed value for the current mode, with the step counter at 0.
REQ-013 The step counter SHALL increment only in RUN; it SHALL hold its value in PAUSE and IDLE.
REQ-014 When the counter equals STEP_DIV-1 in RUN, the block SHALL clear the counter, assert step for 1 cycle, and update led on that same edge.
REQ-015 ROTL: seed 8'h01; each step SHALL rotate led left (8'h80 -> 8'h01).
REQ-016 BOUNCE: seed 8'h01, direction left; each step SHALL shift led one place in the current direction.
REQ-017 BOUNCE: the direction SHALL flip to right at 8'h80 and back to left at 8'h01, giving a 14-step period (01,02,..,80,40,..,02,01).
REQ-018 FILL: seed 8'h00; each step SHALL apply led={led[6:0],1'b1}; a step from 8'hFF SHALL produce 8'h00 (9-step period).
REQ-019 BLINK: seed 8'h00; each step SHALL apply led=~led.
REQ-020 An accepted mode_btn rising edge SHALL set mode=mode+1, wrapping 3->0.
REQ-021 On that same edge the block SHALL load the seed of the new mode into led, clear the step counter, and set BOUNCE direction to left; the FSM state SHALL be unchanged.
REQ-022 Mode edge and step terminal count in the same cycle: the mode change SHALL take effect and step SHALL stay 0.
REQ-023 run_s falls in the cycle the counter reaches terminal count while in RUN: the step SHALL still occur, and the FSM SHALL enter PAUSE on the same edge.
REQ-024 Latency without debounce: mode SHALL change on the 3rd rising clk edge after mode_btn rises (2 synchronizer stages plus the edge-detect register).

Reset
REQ-025 While reset=1: state=IDLE, mode=0, led=8'h01, step=0, counter=0, BOUNCE direction=left, synchronizer and debounce flops=0.
REQ-026 Reset asserted mid-operation SHALL apply REQ-025 immediately (asynchronously); the block SHALL restart from IDLE on the first edge after release.

Configuration
REQ-027 Macro LED_DEBOUNCE_EN defined: the synchronized mode_btn SHALL be accepted only after staying at its new level for DEB_CYCLES consecutive cycles; a change of level before that SHALL restart the count; mode latency = REQ-024 + DEB_CYCLES.
REQ-028 Macro LED_DEBOUNCE_EN undefined: the edge is detected directly on the synchronized signal, with no debounce logic or DEB_CYCLES counter in the design.

Structure
REQ-029 Shared package led_pkg SHALL hold: the mode encodings, the FSM state encodings, and the per-mode seed constants (8'h01, 8'h01, 8'h00, 8'h00).
REQ-030 The step counter SHALL be the sub-module led_step_timer (ports: clk, reset, en, clr, tick; parameter STEP_DIV).

Verification (STEP_DIV=4, DEB_CYCLES=3)
REQ-031 Reset, then run=1 held -> led=01 until the first step, then 02,04 on consecutive step pulses, with step pulses exactly 4 cycles apart.
REQ-032 Mode 1, run=1 for 16 steps -> led sequence 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02,04.
REQ-033 Mode 2, run=1 for 10 steps -> led 01,03,07,0F,1F,3F,7F,FF,00,01; press 1 more -> mode=3, led=00, then FF,00 on the next steps.
REQ-034 run=1 then run=0 for 20 cycles mid-count, then run=1 -> no step pulse while paused; counter resumes from its held value.
REQ-035 Mode edge coinciding with terminal count -> mode increments, led=new seed, step=0; a 2-cycle glitch on mode_btn with LED_DEBOUNCE_EN -> no mode change.
REQ-036 Assert reset during BOUNCE moving right at led=20 -> immediately led=01, mode=0, step=0, IDLE.
